// File: rtl/craft_pkg.sv
// Shared constants and types for the CRAFT round scheduler.
package craft_pkg;

    localparam int CRAFT_ROUNDS  = 32;
    localparam int CRAFT_NIBBLES = 16;

    localparam int KEY_W    = 128;
    localparam int TWEAK_W  = 64;
    localparam int RC_IDX_W = 8;
    localparam int NIB_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/craft_round_scheduler_if.sv
// Request/sequencing bundle between the cipher wrapper and the round scheduler.
interface craft_round_scheduler_if;
    import craft_pkg::*;

    logic                start;
    logic [KEY_W-1:0]    key_in;
    logic [TWEAK_W-1:0]  tweak_in;
    logic                stall;
    logic                busy;
    logic                done;
    logic [KEY_W-1:0]    key_o;
    logic [TWEAK_W-1:0]  tweak_o;
    logic                kr_en;
    logic                kr_ck0;
    logic [RC_IDX_W-1:0] round_o;
    logic [NIB_W-1:0]    nib_o;
    logic                last_round;

    modport master (
        output start, key_in, tweak_in, stall,
        input  busy, done, key_o, tweak_o, kr_en, kr_ck0, round_o, nib_o, last_round
    );

    modport slave (
        input  start, key_in, tweak_in, stall,
        output busy, done, key_o, tweak_o, kr_en, kr_ck0, round_o, nib_o, last_round
    );

endinterface

// File: rtl/craft_round_counter.sv
// Nibble/round counter pair: advances one nibble per enable, bumps the round on wrap.
module craft_round_counter
    import craft_pkg::*;
#(
    parameter int ROUNDS = CRAFT_ROUNDS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_clr,
    input  logic                i_adv,
    output logic [NIB_W-1:0]    o_nib,
    output logic [RC_IDX_W-1:0] o_round,
    output logic [RC_IDX_W-1:0] o_round_next,
    output logic                o_terminal
);

    localparam logic [NIB_W-1:0]    NIB_LAST   = NIB_W'(CRAFT_NIBBLES - 1);
    localparam logic [RC_IDX_W-1:0] ROUND_LAST = RC_IDX_W'(ROUNDS - 1);

    logic [NIB_W-1:0]    r_nib;
    logic [RC_IDX_W-1:0] r_round;
    logic [NIB_W-1:0]    w_nib_next;
    logic [RC_IDX_W-1:0] w_round_next;

    // The round only ever moves by +1 on a nibble wrap, or back to 0 on clear.
    always_comb begin
        w_nib_next   = r_nib;
        w_round_next = r_round;
        if (i_clr) begin
            w_nib_next   = '0;
            w_round_next = '0;
        end else if (i_adv) begin
            w_nib_next = r_nib + NIB_W'(1);
            if (r_nib == NIB_LAST) begin
                w_round_next = r_round + RC_IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_nib   <= '0;
            r_round <= '0;
        end else begin
            r_nib   <= w_nib_next;
            r_round <= w_round_next;
        end
    end

    assign o_nib        = r_nib;
    assign o_round      = r_round;
    assign o_round_next = w_round_next;
    assign o_terminal   = (r_nib == NIB_LAST) && (r_round == ROUND_LAST);

endmodule

// File: rtl/craft_round_scheduler.sv
// Sequencer for the nibble-serial CRAFT datapath: key/tweak capture, round/nibble
// stepping and key-register strobes.
module craft_round_scheduler
    import craft_pkg::*;
#(
    parameter int ROUNDS = CRAFT_ROUNDS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    craft_round_scheduler_if.slave  bus
);

    localparam logic [RC_IDX_W-1:0] ROUND_LAST = RC_IDX_W'(ROUNDS - 1);

    sched_state_t        r_state;
    logic                r_busy;
    logic                r_done;
    logic                r_last_round;
    logic [KEY_W-1:0]    r_key;
    logic [TWEAK_W-1:0]  r_tweak;

    logic                w_run;
    logic                w_clr;
    logic                w_adv;
    logic                w_terminal;
    logic [NIB_W-1:0]    w_nib;
    logic [RC_IDX_W-1:0] w_round;
    logic [RC_IDX_W-1:0] w_round_next;

    assign w_run = (r_state == RUN);
    // Counters sit at zero outside RUN; the DONE->IDLE edge is what returns round_o to 0.
    assign w_clr = !w_run;
    assign w_adv = w_run && !bus.stall && !w_terminal;

    craft_round_counter #(
        .ROUNDS (ROUNDS)
    ) u_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr        (w_clr),
        .i_adv        (w_adv),
        .o_nib        (w_nib),
        .o_round      (w_round),
        .o_round_next (w_round_next),
        .o_terminal   (w_terminal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_last_round <= 1'b0;
            r_key        <= '0;
            r_tweak      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done       <= 1'b0;
                    r_last_round <= 1'b0;
                    if (bus.start) begin
                        r_key   <= bus.key_in;
                        r_tweak <= bus.tweak_in;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (!bus.stall && w_terminal) begin
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_last_round <= 1'b0;
                        r_state      <= DONE;
                    end else begin
                        r_last_round <= (w_round_next == ROUND_LAST);
                    end
                end
                DONE: begin
                    r_done       <= 1'b0;
                    r_last_round <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_busy       <= 1'b0;
                    r_done       <= 1'b0;
                    r_last_round <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.key_o      = r_key;
    assign bus.tweak_o    = r_tweak;
    assign bus.round_o    = w_round;
    assign bus.nib_o      = w_nib;
    assign bus.last_round = r_last_round;
    // ck0 deliberately ignores stall so a stall on nibble 0 keeps the load strobe up.
    assign bus.kr_ck0     = w_run && (w_nib == '0);
    assign bus.kr_en      = w_run && !bus.stall;

endmodule

// File: tb/tb_craft_round_scheduler.sv
// Randomised bench for craft_round_scheduler against a step-count reference model.
module tb_craft_round_scheduler;
    import craft_pkg::*;

    localparam int R = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    craft_round_scheduler_if bus();

    craft_round_scheduler #(.ROUNDS(R)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: phase 0 idle, 1 run, 2 done; m_pos counts completed RUN nibbles 0..16R-1.
    int           m_phase = 0;
    int           m_pos   = 0;
    logic [127:0] m_key   = '0;
    logic [63:0]  m_tweak = '0;

    int acc_cyc, dut_done_cyc, n_done_seen, n_stall, n_kr_low;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", tag, cyc, act, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        cyc++;
        #1;
        if (rst_n && m_phase == 1 && bus.stall) n_stall++;
        if (!rst_n) begin
            m_phase = 0; m_pos = 0; m_key = '0; m_tweak = '0;
        end else begin
            case (m_phase)
                0: if (bus.start) begin
                    m_phase = 1; m_pos = 0;
                    m_key = bus.key_in; m_tweak = bus.tweak_in;
                    acc_cyc = cyc;
                end
                1: if (!bus.stall) begin
                    if (m_pos == 16 * R - 1) m_phase = 2;
                    else m_pos++;
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic drive(input logic st, input logic [127:0] k, input logic [63:0] t,
                         input logic sl, input logic rn);
        bus.start = st; bus.key_in = k; bus.tweak_in = t; bus.stall = sl; rst_n = rn;
        #1;
    endtask

    task automatic compare_outputs();
        int er;
        er = (m_phase == 1) ? m_pos / 16 : (m_phase == 2) ? R - 1 : 0;
        check_eq("busy",  128'(bus.busy),  128'(m_phase == 1));
        check_eq("done",  128'(bus.done),  128'(m_phase == 2));
        check_eq("round", 128'(bus.round_o), 128'(er));
        if (m_phase != 2) check_eq("nib", 128'(bus.nib_o), 128'((m_phase == 1) ? m_pos % 16 : 0));
        check_eq("kr_en",  128'(bus.kr_en),  128'(m_phase == 1 && !bus.stall));
        check_eq("kr_ck0", 128'(bus.kr_ck0), 128'(m_phase == 1 && m_pos % 16 == 0));
        check_eq("last_round", 128'(bus.last_round), 128'(m_phase == 1 && m_pos / 16 == R - 1));
        check_eq("key_o",   bus.key_o,          m_key);
        check_eq("tweak_o", 128'(bus.tweak_o),  128'(m_tweak));
        if (bus.done) begin n_done_seen++; dut_done_cyc = cyc; end
        if (m_phase == 1 && !bus.kr_en) n_kr_low++;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // mode 0 nominal + ignored starts, 1 directed stall, 2 noisy start/stall, 3 reset mid-op, 4 random stall
    task automatic run_op(input int mode);
        int  off;
        int  stl;
        bit  fin;
        logic st, sl, rn;
        logic [127:0] k0;
        logic [63:0]  t0;
        k0 = (mode == 0) ? 128'h0123456789ABCDEF0123456789ABCDEF : rnd128();
        t0 = (mode == 0) ? 64'hFEDCBA9876543210 : {$urandom, $urandom};
        n_stall = 0; n_kr_low = 0; n_done_seen = 0; dut_done_cyc = -1; acc_cyc = -1;
        off = 0; stl = 0; fin = 1'b0;
        drive(1'b1, k0, t0, 1'b0, 1'b1);
        compare_outputs();
        while (!fin && off < 800) begin
            edge_step();
            off++;
            if (m_phase == 0) begin
                fin = 1'b1;
            end else begin
                st = 1'b0; sl = 1'b0; rn = 1'b1;
                case (mode)
                    0: st = (off == 40 || off == 513);
                    1: begin
                        sl = (m_phase == 1 && m_pos == 5 * 16 + 7 && stl < 3);
                        if (sl) stl++;
                    end
                    2: begin st = 1'($urandom % 2); sl = ($urandom % 5 == 0); end
                    3: begin rn = (off != 200); st = 1'($urandom % 2); sl = ($urandom % 4 == 0); end
                    default: sl = ($urandom % 3 == 0);
                endcase
                drive(st, rnd128(), {$urandom, $urandom}, sl, rn);
                compare_outputs();
            end
        end
        drive(1'b0, rnd128(), {$urandom, $urandom}, 1'b0, 1'b1);
        compare_outputs();
        check_eq("op_terminated", 128'(fin), 128'(1));
        if (mode == 3) begin
            check_eq("no_done_after_reset", 128'(n_done_seen), 128'(0));
        end else begin
            check_eq("done_pulses", 128'(n_done_seen), 128'(1));
            check_eq("latency", 128'(dut_done_cyc - acc_cyc), 128'(16 * R + n_stall));
        end
        if (mode == 1) check_eq("kr_en_low_cycles", 128'(n_kr_low), 128'(3));
        $display("op mode %0d: accepted at %0d, done at %0d, stalls %0d, vectors %0d",
                 mode, acc_cyc, dut_done_cyc, n_stall, n_vec);
    endtask

    initial begin
        int modes [7] = '{0, 1, 2, 3, 4, 4, 2};
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (2) begin
            edge_step();
            drive(1'b0, rnd128(), {$urandom, $urandom}, 1'($urandom % 2), 1'b0);
            compare_outputs();
        end
        edge_step();
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        compare_outputs();
        edge_step();
        drive(1'b0, '0, '0, 1'b1, 1'b1);
        compare_outputs();
        edge_step();
        foreach (modes[i]) run_op(modes[i]);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
